sar_host_seq: RTL

SAR_HOST_SEQ -- requirements
Module: sar_host_seq

---
 rtl/sar_host_seq_pkg.sv | 22 ++
 rtl/sar_result_fifo.sv | 82 ++++++++
 rtl/sar_host_seq.sv | 133 +++++++++++++
 3 files changed

// File: rtl/sar_host_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sar_host_seq_pkg
// Function : Shared constants and state encoding for the SAR host sequencer.
// Revision : 1.0
// ============================================================================
package sar_host_seq_pkg;

    localparam int unsigned RES_W       = 3;
    localparam int unsigned DEPTH_DEF   = 4;
    localparam int unsigned TIMEOUT_DEF = 32;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_START   = 3'd1;
    localparam state_t ST_BUSY    = 3'd2;
    localparam state_t ST_CAPTURE = 3'd3;
    localparam state_t ST_GAP     = 3'd4;

endpackage
`default_nettype wire

// File: rtl/sar_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sar_result_fifo
// Function : First-word-fall-through result FIFO with registered head and flags.
// Revision : 1.0
// ============================================================================
module sar_result_fifo
    import sar_host_seq_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [RES_W-1:0] data_i,
    output logic [RES_W-1:0] data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             drop_o
);

    logic [RES_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RES_W-1:0] head_q, head_d;
    logic             empty_q, full_q;
    logic             do_push, do_pop;

    always_comb begin
        do_pop  = pop_i && !empty_q;
        do_push = push_i && (!full_q || do_pop);
        drop_o  = push_i && full_q && !do_pop;
        wr_d    = do_push ? wr_q + PTR_W'(1) : wr_q;
        rd_d    = do_pop  ? rd_q + PTR_W'(1) : rd_q;
        cnt_d   = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        // Head is precomputed so rdData is a flop; a same-cycle push may land at the new head.
        head_d = '0;
        if (cnt_d != '0) begin
            head_d = (do_push && (wr_q == rd_d)) ? data_i : mem_q[rd_d];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            head_q  <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= data_i;
            end
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            empty_q <= (cnt_d == '0);
            full_q  <= (cnt_d == CNT_W'(DEPTH));
        end
    end

    assign data_o  = head_q;
    assign count_o = cnt_q;
    assign empty_o = empty_q;
    assign full_o  = full_q;

endmodule
`default_nettype wire

// File: rtl/sar_host_seq.sv
`default_nettype none
// ============================================================================
// Module   : sar_host_seq
// Function : Periodic SAR conversion sequencer with handshake timeout and result FIFO.
// Revision : 1.0
// ============================================================================
module sar_host_seq
    import sar_host_seq_pkg::*;
#(
    parameter int unsigned DEPTH   = DEPTH_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [7:0]                     period,
    output logic                           nStartCnv,
    input  logic                           nEndCnv,
    input  logic [RES_W-1:0]               dataIn,
    input  logic                           rdEn,
    output logic [RES_W-1:0]               rdData,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           empty,
    output logic                           full,
    output logic                           busy,
    output logic                           overflow,
    output logic                           timeout,
    input  logic                           clrErr
);

    localparam int unsigned WAIT_W = $clog2(TIMEOUT);

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [7:0]          gap_q, gap_d;
    logic                nstart_q, nstart_d;
    logic                busy_q, busy_d;
    logic                ovf_q, ovf_d;
    logic                to_q, to_d;
    logic                to_set, push, drop;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            wait_q   <= '0;
            gap_q    <= '0;
            nstart_q <= 1'b1;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            gap_q    <= gap_d;
            nstart_q <= nstart_d;
            busy_q   <= busy_d;
            ovf_q    <= ovf_d;
            to_q     <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        gap_d   = gap_q;
        to_set  = 1'b0;
        push    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_START;
                    wait_d  = '0;
                end
            end
            ST_START, ST_BUSY: begin
                // START waits for the converter to go busy, BUSY waits for it to finish.
                if ((state_q == ST_START) ? nEndCnv : !nEndCnv) begin
                    state_d = (state_q == ST_START) ? ST_BUSY : ST_CAPTURE;
                    wait_d  = '0;
                end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                    state_d = ST_GAP;
                    gap_d   = period;
                    to_set  = 1'b1;
                end else begin
                    wait_d  = wait_q + WAIT_W'(1);
                end
            end
            ST_CAPTURE: begin
                push    = 1'b1;
                state_d = ST_GAP;
                gap_d   = period;
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d   = gap_q - 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        nstart_d = (state_d != ST_START);
        busy_d   = (state_d == ST_START) || (state_d == ST_BUSY);
        // A flag raised in the same cycle as clrErr survives the clear.
        to_d     = (to_q && !clrErr) || to_set;
        ovf_d    = (ovf_q && !clrErr) || drop;
    end

    sar_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clock),
        .rst_ni  (reset),
        .push_i  (push),
        .pop_i   (rdEn),
        .data_i  (dataIn),
        .data_o  (rdData),
        .count_o (count),
        .empty_o (empty),
        .full_o  (full),
        .drop_o  (drop)
    );

    assign nStartCnv = nstart_q;
    assign busy      = busy_q;
    assign overflow  = ovf_q;
    assign timeout   = to_q;

endmodule
`default_nettype wire
